// File: rtl/ocd_dbg_pkg.sv
// rtl/ocd_dbg_pkg.sv - shared widths, IR encodings and command entry type for the OCD bridge
package ocd_dbg_pkg;

  localparam int OCD_SR_W = 38;
  localparam int OCD_IR_W = 2;

  typedef enum logic [OCD_IR_W-1:0] {
    OCD_IR_OCIMEM    = 2'd0,
    OCD_IR_TRACEMEM  = 2'd1,
    OCD_IR_BREAK     = 2'd2,
    OCD_IR_TRACECTRL = 2'd3
  } ocd_ir_e;

  typedef struct packed {
    logic [OCD_IR_W-1:0] ir;
    logic [OCD_SR_W-1:0] jdo;
  } ocd_entry_t;

endpackage

// File: rtl/ocd_toggle_sync.sv
// rtl/ocd_toggle_sync.sv - toggle synchronizer turning a TCK-domain level flip into a one-cycle event
module ocd_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tgl,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/ocd_debug_cmd_bridge.sv
// rtl/ocd_debug_cmd_bridge.sv - captures JTAG Update-DR/IR events into a command FIFO on the system clock
module ocd_debug_cmd_bridge
  import ocd_dbg_pkg::*;
#(
  parameter int SR_W        = OCD_SR_W,
  parameter int IR_W        = OCD_IR_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       udr_tgl,
  input  logic                       uir_tgl,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [SR_W-1:0]            sr,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [IR_W-1:0]            cmd_ir,
  output logic [SR_W-1:0]            cmd_jdo,
  output logic                       ir_update,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = IR_W + SR_W;
  localparam int CW = $clog2(SYNC_STAGES + 1);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr_vis;
  logic [CW-1:0] arm_cnt;
  logic          armed;
  logic          udr_raw, uir_raw, udr_evt, uir_evt;
  logic          full, pop, push;

  ocd_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset_n(reset_n), .tgl(udr_tgl), .evt(udr_raw)
  );

  ocd_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset_n(reset_n), .tgl(uir_tgl), .evt(uir_raw)
  );

  // Events are masked until the synchronizers have flushed their reset state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      if (arm_cnt == CW'(SYNC_STAGES)) armed <= 1'b1;
      else                             arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign udr_evt = udr_raw & armed;
  assign uir_evt = uir_raw & armed;

  assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  // A new entry becomes visible to the consumer one cycle after it is written.
  assign cmd_valid = (wptr_vis != rptr);
  assign pop       = cmd_valid && cmd_ready;
  assign push      = udr_evt && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      wptr_vis <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wptr_vis <= wptr;
      if (push) begin
        mem[wptr[AW-1:0]] <= {ir_in, sr};
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_update <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      ir_update <= uir_evt;
      if (udr_evt && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)       overflow <= 1'b0;
    end
  end

  assign {cmd_ir, cmd_jdo} = mem[rptr[AW-1:0]];
  assign level             = LW'(wptr - rptr);

endmodule
